// File: rtl/gl_triangle_fifo.sv
// gl_triangle_fifo: gathers vertices into triangles, buffers up to DEPTH of
// them, and hands the oldest one to the rasterizer. A triangle stays stored
// (and counted) until the rasterizer flags it as done.
module gl_triangle_fifo #(
    parameter int VERTEX_TYPE_SIZE = 96,
    parameter int DEPTH            = 4,
    parameter int CNT_W            = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vtx_valid,
    input  logic [VERTEX_TYPE_SIZE-1:0] vtx_data,
    output logic                        vtx_ready,
    input  logic                        prim_restart,
    output logic                        fifo_ready,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_out1,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_out2,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_out3,
    input  logic                        raster_ready,
    output logic [CNT_W-1:0]            tri_count,
    output logic                        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int VW = VERTEX_TYPE_SIZE;
    localparam int TW = 3 * VERTEX_TYPE_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            issue;

    logic [1:0]      vc;
    logic [VW-1:0]   stage0;
    logic [VW-1:0]   stage1;
    logic [TW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            rr_q;

    logic            vtx_take;
    logic            push;
    logic            rr_rise;
    logic            retire;

    // The third vertex may only land when a slot is free; the first two
    // vertices only touch the staging registers, so they are never stalled.
    assign vtx_ready = (vc != 2'd2) || (tri_count != CNT_W'(DEPTH));
    // A restart wins over a vertex arriving in the same cycle.
    assign vtx_take  = vtx_valid && vtx_ready && !prim_restart;
    assign push      = vtx_take && (vc == 2'd2);
    assign rr_rise   = raster_ready && !rr_q;
    assign retire    = (state == BUSY) && rr_rise;

    // Issue FSM next-state logic; retire only ever happens out of BUSY, so
    // IDLE never sees a same-cycle retire.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (tri_count != '0) begin
                    issue      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = BUSY;
            BUSY: begin
                if (rr_rise) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state: FSM, vertex counter, pointers, occupancy and output regs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vc         <= 2'd0;
            wptr       <= '0;
            rptr       <= '0;
            tri_count  <= '0;
            rr_q       <= 1'b0;
            fifo_ready <= 1'b0;
            busy       <= 1'b0;
            fifo_out1  <= '0;
            fifo_out2  <= '0;
            fifo_out3  <= '0;
        end else begin
            state      <= state_next;
            rr_q       <= raster_ready;
            fifo_ready <= issue;
            busy       <= (state_next == BUSY);

            if (prim_restart) begin
                vc <= 2'd0;
            end else if (vtx_take) begin
                vc <= (vc == 2'd2) ? 2'd0 : vc + 2'd1;
            end

            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (retire) begin
                rptr <= rptr + AW'(1);
            end

            case ({push, retire})
                2'b10:   tri_count <= tri_count + CNT_W'(1);
                2'b01:   tri_count <= tri_count - CNT_W'(1);
                default: tri_count <= tri_count;
            endcase

            if (issue) begin
                fifo_out1 <= mem[rptr][TW-1 -: VW];
                fifo_out2 <= mem[rptr][TW-VW-1 -: VW];
                fifo_out3 <= mem[rptr][VW-1:0];
            end
        end
    end

    // Vertex staging and triangle storage; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (vtx_take && (vc == 2'd0)) begin
            stage0 <= vtx_data;
        end
        if (vtx_take && (vc == 2'd1)) begin
            stage1 <= vtx_data;
        end
        if (push) begin
            mem[wptr] <= {stage0, stage1, vtx_data};
        end
    end

endmodule

// File: tb/tb_gl_triangle_fifo.sv
// Directed testbench for gl_triangle_fifo (DEPTH=4).
module tb_gl_triangle_fifo;

    localparam int W = 96;

    logic          clk;
    logic          rst;
    logic          vtx_valid;
    logic [W-1:0]  vtx_data;
    logic          vtx_ready;
    logic          prim_restart;
    logic          fifo_ready;
    logic [W-1:0]  fifo_out1;
    logic [W-1:0]  fifo_out2;
    logic [W-1:0]  fifo_out3;
    logic          raster_ready;
    logic [2:0]    tri_count;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int unstable = 0;
    logic [3*W-1:0] issued[$];
    logic [3*W-1:0] held;

    gl_triangle_fifo #(.VERTEX_TYPE_SIZE(96), .DEPTH(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .vtx_valid(vtx_valid),
        .vtx_data(vtx_data),
        .vtx_ready(vtx_ready),
        .prim_restart(prim_restart),
        .fifo_ready(fifo_ready),
        .fifo_out1(fifo_out1),
        .fifo_out2(fifo_out2),
        .fifo_out3(fifo_out3),
        .raster_ready(raster_ready),
        .tri_count(tri_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every issued triangle and watch the outputs for changes while busy.
    always @(negedge clk) begin
        if (fifo_ready) begin
            pulses = pulses + 1;
            issued.push_back({fifo_out1, fifo_out2, fifo_out3});
            held = {fifo_out1, fifo_out2, fifo_out3};
        end else if (busy && ({fifo_out1, fifo_out2, fifo_out3} !== held)) begin
            unstable = unstable + 1;
        end
    end

    function automatic logic [W-1:0] mkv(input int t, input int v);
        mkv = {32'h3F800000 + 32'(t), 32'h40000000 + 32'(v), 32'(t * 16 + v)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vtx(input logic [W-1:0] d);
        int n;
        vtx_data  = d;
        vtx_valid = 1'b1;
        n = 0;
        while (!vtx_ready && n < 100) begin
            tick();
            n++;
        end
        if (!vtx_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: vtx_ready got %b required 1", vtx_ready);
        end
        tick();
        vtx_valid = 1'b0;
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!busy && n < 100) begin
            tick();
            n++;
        end
        if (!busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy got %b required 1", busy);
        end
    endtask

    task automatic retire_one();
        wait_busy();
        raster_ready = 1'b1;
        tick();
        raster_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (fifo_ready !== 1'b0) begin errors++; $display("FAIL rst_fifo_ready: got %b required 0", fifo_ready); end
        checks++; if (fifo_out1 !== '0) begin errors++; $display("FAIL rst_fifo_out1: got %h required 0", fifo_out1); end
        checks++; if (tri_count !== 3'd0) begin errors++; $display("FAIL rst_tri_count: got %0d required 0", tri_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        rst = 1'b0;
        tick();
        checks++; if (vtx_ready !== 1'b1) begin errors++; $display("FAIL rst_vtx_ready: got %b required 1", vtx_ready); end
    endtask

    task automatic test_basic();
        logic [W-1:0] v1, v2, v3;
        int p0;
        v1 = {32'h3F800000, 32'h3F000000, 32'h00000001};
        v2 = {32'h40000000, 32'h3F000000, 32'h00000002};
        v3 = {32'h40400000, 32'h3F000000, 32'h00000003};
        p0 = pulses;
        push_vtx(v1);
        push_vtx(v2);
        push_vtx(v3);
        checks++; if (tri_count !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d required 1", tri_count); end
        checks++; if (fifo_ready !== 1'b0) begin errors++; $display("FAIL basic_early_pulse: got %b required 0", fifo_ready); end
        tick();
        checks++; if (fifo_ready !== 1'b1) begin errors++; $display("FAIL basic_pulse: got %b required 1", fifo_ready); end
        checks++; if (fifo_out1[95:64] !== 32'h3F800000) begin errors++; $display("FAIL basic_x1: got %h required 3f800000", fifo_out1[95:64]); end
        checks++; if ({fifo_out1, fifo_out2, fifo_out3} !== {v1, v2, v3}) begin errors++; $display("FAIL basic_tri: got %h required %h", {fifo_out1, fifo_out2, fifo_out3}, {v1, v2, v3}); end
        tick();
        checks++; if (fifo_ready !== 1'b0) begin errors++; $display("FAIL basic_pulse_end: got %b required 0", fifo_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b required 1", busy); end
        repeat (3) tick();
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL basic_pulse_count: got %0d required 1", pulses - p0); end
    endtask

    task automatic test_retire_hold();
        int p0;
        p0 = pulses;
        raster_ready = 1'b1;
        repeat (20) tick();
        checks++; if (tri_count !== 3'd0) begin errors++; $display("FAIL hold_count: got %0d required 0", tri_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy: got %b required 0", busy); end
        checks++; if (pulses !== p0) begin errors++; $display("FAIL hold_pulses: got %0d required %0d", pulses, p0); end
        raster_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_full();
        issued.delete();
        for (int t = 0; t < 4; t++)
            for (int v = 0; v < 3; v++)
                push_vtx(mkv(t, v));
        checks++; if (tri_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d required 4", tri_count); end
        push_vtx(mkv(4, 0));
        push_vtx(mkv(4, 1));
        vtx_data  = mkv(4, 2);
        vtx_valid = 1'b1;
        checks++; if (vtx_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", vtx_ready); end
        tick();
        checks++; if (tri_count !== 3'd4) begin errors++; $display("FAIL full_hold_count: got %0d required 4", tri_count); end
        checks++; if (vtx_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready: got %b required 0", vtx_ready); end
        raster_ready = 1'b1;
        tick();
        raster_ready = 1'b0;
        checks++; if (tri_count !== 3'd3) begin errors++; $display("FAIL full_retire_count: got %0d required 3", tri_count); end
        checks++; if (vtx_ready !== 1'b1) begin errors++; $display("FAIL full_retire_ready: got %b required 1", vtx_ready); end
        tick();
        vtx_valid = 1'b0;
        checks++; if (tri_count !== 3'd4) begin errors++; $display("FAIL full_accept_count: got %0d required 4", tri_count); end
        repeat (4) retire_one();
        repeat (2) tick();
        checks++; if (tri_count !== 3'd0) begin errors++; $display("FAIL full_drain_count: got %0d required 0", tri_count); end
        checks++; if (issued.size() !== 5) begin errors++; $display("FAIL full_issue_num: got %0d required 5", issued.size()); end
        for (int t = 0; t < 5 && t < issued.size(); t++) begin
            checks++;
            if (issued[t] !== {mkv(t, 0), mkv(t, 1), mkv(t, 2)}) begin
                errors++;
                $display("FAIL full_order%0d: got %h required %h", t, issued[t], {mkv(t, 0), mkv(t, 1), mkv(t, 2)});
            end
        end
    endtask

    task automatic test_restart();
        issued.delete();
        push_vtx(mkv(9, 0));
        push_vtx(mkv(9, 1));
        prim_restart = 1'b1;
        vtx_data     = mkv(9, 2);
        vtx_valid    = 1'b1;
        tick();
        prim_restart = 1'b0;
        vtx_valid    = 1'b0;
        checks++; if (tri_count !== 3'd0) begin errors++; $display("FAIL restart_count: got %0d required 0", tri_count); end
        push_vtx(mkv(10, 0));
        push_vtx(mkv(10, 1));
        push_vtx(mkv(10, 2));
        repeat (3) tick();
        checks++; if (issued.size() !== 1) begin errors++; $display("FAIL restart_issue_num: got %0d required 1", issued.size()); end
        checks++; if ({fifo_out1, fifo_out2, fifo_out3} !== {mkv(10, 0), mkv(10, 1), mkv(10, 2)}) begin errors++; $display("FAIL restart_tri: got %h required %h", {fifo_out1, fifo_out2, fifo_out3}, {mkv(10, 0), mkv(10, 1), mkv(10, 2)}); end
        retire_one();
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        int p0;
        for (int t = 0; t < 3; t++)
            for (int v = 0; v < 3; v++)
                push_vtx(mkv(20 + t, v));
        push_vtx(mkv(29, 0));
        wait_busy();
        checks++; if (tri_count !== 3'd3) begin errors++; $display("FAIL arst_pre_count: got %0d required 3", tri_count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b required 0", busy); end
        checks++; if (tri_count !== 3'd0) begin errors++; $display("FAIL arst_count: got %0d required 0", tri_count); end
        checks++; if ({fifo_out1, fifo_out2, fifo_out3} !== '0) begin errors++; $display("FAIL arst_out: got %h required 0", {fifo_out1, fifo_out2, fifo_out3}); end
        tick();
        rst = 1'b0;
        p0  = pulses;
        repeat (5) tick();
        checks++; if (pulses !== p0) begin errors++; $display("FAIL arst_no_pulse: got %0d required %0d", pulses, p0); end
        issued.delete();
        push_vtx(mkv(30, 0));
        push_vtx(mkv(30, 1));
        checks++; if (pulses !== p0) begin errors++; $display("FAIL arst_partial_pulse: got %0d required %0d", pulses, p0); end
        push_vtx(mkv(30, 2));
        repeat (3) tick();
        checks++; if (issued.size() !== 1) begin errors++; $display("FAIL arst_issue_num: got %0d required 1", issued.size()); end
        checks++; if ({fifo_out1, fifo_out2, fifo_out3} !== {mkv(30, 0), mkv(30, 1), mkv(30, 2)}) begin errors++; $display("FAIL arst_tri: got %h required %h", {fifo_out1, fifo_out2, fifo_out3}, {mkv(30, 0), mkv(30, 1), mkv(30, 2)}); end
        retire_one();
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        int u0;
        issued.delete();
        u0 = unstable;
        fork
            begin
                int i, n;
                bit take;
                i = 0;
                n = 0;
                while (i < 27 && n < 3000) begin
                    vtx_data  = mkv(40 + i / 3, i % 3);
                    vtx_valid = 1'($urandom_range(0, 1));
                    take      = vtx_valid && vtx_ready;
                    tick();
                    if (take) i++;
                    n++;
                end
                vtx_valid = 1'b0;
            end
            begin
                for (int r = 0; r < 9; r++) begin
                    wait_busy();
                    repeat ($urandom_range(0, 5)) tick();
                    raster_ready = 1'b1;
                    tick();
                    raster_ready = 1'b0;
                    tick();
                end
            end
        join
        repeat (3) tick();
        checks++; if (tri_count !== 3'd0) begin errors++; $display("FAIL b2b_count: got %0d required 0", tri_count); end
        checks++; if (unstable !== u0) begin errors++; $display("FAIL b2b_stable: got %0d changes required 0", unstable - u0); end
        checks++; if (issued.size() !== 9) begin errors++; $display("FAIL b2b_issue_num: got %0d required 9", issued.size()); end
        for (int t = 0; t < 9 && t < issued.size(); t++) begin
            checks++;
            if (issued[t] !== {mkv(40 + t, 0), mkv(40 + t, 1), mkv(40 + t, 2)}) begin
                errors++;
                $display("FAIL b2b_order%0d: got %h required %h", t, issued[t], {mkv(40 + t, 0), mkv(40 + t, 1), mkv(40 + t, 2)});
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        vtx_valid    = 1'b0;
        vtx_data     = '0;
        prim_restart = 1'b0;
        raster_ready = 1'b0;
        held         = '0;
        test_reset();
        test_basic();
        test_retire_hold();
        test_full();
        test_restart();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
